// File: rtl/qadd_rr_arbiter_if.sv
// rtl/qadd_rr_arbiter_if.sv - request/result bundle between requesters, downstream and the adder arbiter
interface qadd_rr_arbiter_if #(
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic [NREQ-1:0]   req_ready;
  logic              res_valid;
  logic [N-1:0]      res_data;
  logic [IDW-1:0]    res_id;
  logic              res_ovf;
  logic              res_ready;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id, res_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id, res_ovf
  );
endinterface

// File: rtl/qadd_rr_arbiter.sv
// rtl/qadd_rr_arbiter.sv - round-robin arbiter sharing one sign-magnitude Q-format adder
module qadd #(
  parameter int Q = 15,
  parameter int N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] c_o,
  output logic         ovf_o
);
  // Fraction width does not change sign-magnitude addition; it only rides along.
  if (Q > N - 1) begin : g_q_wider_than_magnitude
  end

  logic [N-1:0] ma;
  logic [N-1:0] mb;
  logic [N-1:0] msum;

  assign ma = {1'b0, a_i[N-2:0]};
  assign mb = {1'b0, b_i[N-2:0]};

  always_comb begin
    msum  = '0;
    c_o   = '0;
    ovf_o = 1'b0;
    if (a_i[N-1] == b_i[N-1]) begin
      msum  = ma + mb;
      c_o   = {a_i[N-1], msum[N-2:0]};
      ovf_o = msum[N-1];
    end else if (ma > mb) begin
      msum = ma - mb;
      c_o  = {a_i[N-1], msum[N-2:0]};
    end else begin
      // A zero difference is always reported as +0.
      msum = mb - ma;
      c_o  = {(msum != '0) & b_i[N-1], msum[N-2:0]};
    end
  end
endmodule

module qadd_rr_arbiter #(
  parameter int Q    = 15,
  parameter int N    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  qadd_rr_arbiter_if.slave  bus
);
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  cand;
  int              scan_idx;
  logic            found;
  logic            can_accept;
  logic            accept;
  logic [NREQ-1:0] rdy;
  logic [N-1:0]    op_a, op_b, sum;
  logic            sum_ovf;

  logic            res_valid_q, res_valid_d;
  logic [N-1:0]    res_data_q, res_data_d;
  logic [IDW-1:0]  res_id_q, res_id_d;
  logic            res_ovf_q, res_ovf_d;

  // Scan begins just past the last winner and wraps, so the last winner ranks lowest.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = 0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NREQ) scan_idx = scan_idx - NREQ;
      cand = IDW'(scan_idx);
      if (!found && bus.req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign can_accept = !res_valid_q || bus.res_ready;
  assign accept     = found && can_accept && !rst;

  always_comb begin
    rdy = '0;
    if (accept) rdy[win] = 1'b1;
  end
  assign bus.req_ready = rdy;

  assign op_a = bus.req_a[win*N +: N];
  assign op_b = bus.req_b[win*N +: N];

  qadd #(.Q(Q), .N(N)) u_qadd (
    .a_i   (op_a),
    .b_i   (op_b),
    .c_o   (sum),
    .ovf_o (sum_ovf)
  );

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;
    res_ovf_d   = res_ovf_q;
    ptr_d       = ptr_q;
    if (accept) begin
      res_valid_d = 1'b1;
      res_data_d  = sum;
      res_id_d    = win;
      res_ovf_d   = sum_ovf;
      ptr_d       = win;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      res_ovf_q   <= 1'b0;
      ptr_q       <= IDW'(NREQ - 1);
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      res_ovf_q   <= res_ovf_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_ovf   = res_ovf_q;
endmodule

// File: tb/tb_qadd_rr_arbiter.sv
// tb/tb_qadd_rr_arbiter.sv - directed and randomized checks of qadd_rr_arbiter against a queue-level model
module tb_qadd_rr_arbiter;
  localparam int Q    = 15;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk;
  logic rst;
  logic chk_en;
  int   vectors;
  int   fails;

  qadd_rr_arbiter_if #(.N(N), .NREQ(NREQ), .IDW(IDW)) bus ();

  qadd_rr_arbiter #(.Q(Q), .N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {ovf, sum} from the sign-magnitude rules on plain integers.
  function automatic logic [32:0] model_add(input logic [31:0] a, input logic [31:0] b);
    longint unsigned ma, mb, s;
    logic            sa, sb, o;
    logic [31:0]     r;
    sa = a[31];
    sb = b[31];
    ma = longint'(a[30:0]);
    mb = longint'(b[30:0]);
    o  = 1'b0;
    if (sa == sb) begin
      s = ma + mb;
      o = (s >= 64'h8000_0000);
      r = {sa, 31'(s % 64'h8000_0000)};
    end else if (ma > mb) begin
      r = {sa, 31'(ma - mb)};
    end else begin
      s = mb - ma;
      r = {(s != 0) ? sb : 1'b0, 31'(s)};
    end
    return {o, r};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: the held result and the pointer, as the rules describe them.
  logic            m_valid;
  logic [31:0]     m_data;
  logic            m_ovf;
  int              m_id;
  int              m_ptr;

  initial begin
    m_valid = 1'b0;
    m_data  = '0;
    m_ovf   = 1'b0;
    m_id    = 0;
    m_ptr   = NREQ - 1;
    forever begin
      logic [NREQ-1:0] exp_rdy;
      logic [32:0]     r;
      int              w;
      int              idx;
      @(negedge clk);
      exp_rdy = '0;
      w = -1;
      if (!rst && (!m_valid || bus.res_ready)) begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (w < 0 && bus.req_valid[idx]) w = idx;
        end
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      if (chk_en) begin
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
        check("res_valid", 64'(bus.res_valid), 64'(m_valid));
        check("res_data",  64'(bus.res_data),  64'(m_data));
        check("res_id",    64'(bus.res_id),    64'(m_id));
        check("res_ovf",   64'(bus.res_ovf),   64'(m_ovf));
      end
      if (rst) begin
        m_valid = 1'b0;
        m_data  = '0;
        m_ovf   = 1'b0;
        m_id    = 0;
        m_ptr   = NREQ - 1;
      end else if (w >= 0) begin
        r       = model_add(bus.req_a[w*N +: N], bus.req_b[w*N +: N]);
        m_valid = 1'b1;
        m_data  = r[31:0];
        m_ovf   = r[32];
        m_id    = w;
        m_ptr   = w;
      end else if (m_valid && bus.res_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0:       return {s, 31'h7FFF_FFFF};
      1:       return {s, 31'd0};
      2:       return {s, 31'($urandom_range(0, 3))};
      default: return $urandom;
    endcase
  endfunction

  task automatic op1(input int idx, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ed, input logic eo);
    logic [NREQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    tick();
    bus.req_valid          = oh;
    bus.req_a[idx*N +: N]  = a;
    bus.req_b[idx*N +: N]  = b;
    bus.res_ready          = 1'b1;
    @(negedge clk);
    check("op_grant", 64'(bus.req_ready), 64'(oh));
    tick();
    bus.req_valid = '0;
    @(negedge clk);
    check("op_valid", 64'(bus.res_valid), 64'd1);
    check("op_data",  64'(bus.res_data),  64'(ed));
    check("op_id",    64'(bus.res_id),    64'(idx));
    check("op_ovf",   64'(bus.res_ovf),   64'(eo));
  endtask

  initial begin
    logic [NREQ-1:0] oh;
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] acc;
    logic [32:0]     exp0;
    vectors = 0;
    fails   = 0;
    chk_en  = 1'b0;
    rst     = 1'b1;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("rst_valid", 64'(bus.res_valid), 64'd0);
    check("rst_data",  64'(bus.res_data),  64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd0);
    tick();
    rst = 1'b0;

    op1(0, 32'h0000_8000, 32'h0000_4000, 32'h0000_C000, 1'b0);
    op1(1, 32'h0000_4000, 32'h8000_4000, 32'h0000_0000, 1'b0);
    op1(1, 32'h0000_4000, 32'h8000_8000, 32'h8000_4000, 1'b0);
    op1(1, 32'h8000_2000, 32'h0000_1000, 32'h8000_1000, 1'b0);
    op1(2, 32'h7FFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1);
    op1(3, 32'hFFFF_FFFF, 32'h8000_0001, 32'h8000_0000, 1'b1);
    op1(2, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // All requesters valid straight out of reset: strict rotation 0,1,2,3,0,1.
    tick();
    rst           = 1'b1;
    bus.req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*N +: N] = rand_word();
      bus.req_b[i*N +: N] = rand_word();
    end
    bus.res_ready = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      oh = '0;
      oh[i % NREQ] = 1'b1;
      check("rr_grant", 64'(bus.req_ready), 64'(oh));
      if (i > 0) begin
        check("rr_id",    64'(bus.res_id),    64'((i - 1) % NREQ));
        check("rr_valid", 64'(bus.res_valid), 64'd1);
      end
    end

    // Backpressure after the first accept, then release.
    tick();
    rst           = 1'b1;
    bus.res_ready = 1'b0;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("bp_first_grant", 64'(bus.req_ready), 64'h1);
    exp0 = model_add(bus.req_a[0 +: N], bus.req_b[0 +: N]);
    repeat (5) begin
      @(negedge clk);
      check("bp_ready", 64'(bus.req_ready), 64'h0);
      check("bp_valid", 64'(bus.res_valid), 64'd1);
      check("bp_id",    64'(bus.res_id),    64'd0);
      check("bp_data",  64'(bus.res_data),  64'(exp0[31:0]));
    end
    tick();
    bus.res_ready = 1'b1;
    @(negedge clk);
    check("bp_release_grant", 64'(bus.req_ready), 64'h2);
    check("bp_release_valid", 64'(bus.res_valid), 64'd1);
    @(negedge clk);
    check("bp_next_id",    64'(bus.res_id),    64'd1);
    check("bp_next_valid", 64'(bus.res_valid), 64'd1);

    // Reset while a result is held under backpressure.
    tick();
    bus.res_ready = 1'b0;
    rst           = 1'b1;
    bus.req_valid = 4'b0101;
    @(negedge clk);
    check("mid_rst_ready", 64'(bus.req_ready), 64'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(bus.res_valid), 64'd0);
    check("mid_rst_data",  64'(bus.res_data),  64'd0);
    check("mid_rst_id",    64'(bus.res_id),    64'd0);
    check("mid_rst_ovf",   64'(bus.res_ovf),   64'd0);
    check("mid_rst_grant", 64'(bus.req_ready), 64'h1);

    // Random traffic: requesters hold until accepted, occasionally give up.
    tick();
    bus.req_valid = '0;
    pend = '0;
    repeat (3000) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            bus.req_a[i*N +: N] = rand_word();
            bus.req_b[i*N +: N] = rand_word();
          end
        end else if ($urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      bus.req_valid = pend;
      bus.res_ready = ($urandom_range(0, 9) < 7);
      rst           = ($urandom_range(0, 499) == 0);
      @(negedge clk);
      acc = bus.req_valid & bus.req_ready;
      tick();
      pend = pend & ~acc;
    end

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
